// File: rtl/uart_baud_controller.sv
// Baud-timing controller: one programmable divisor shared by independent
// TX and RX timing channels. TX gets a strobe per bit period; RX gets an
// oversample strobe and a mid-bit sample strobe, re-aligned on start edges.
module uart_baud_controller #(
    parameter int unsigned NATIVE_CLK_FREQUENCY = 50000000,
    parameter int unsigned DEFAULT_BAUD         = 115200,
    parameter int unsigned OVERSAMPLE           = 16,
    parameter int unsigned DIV_WIDTH            = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 cfg_ready,
    output logic [DIV_WIDTH-1:0] div_current,
    input  logic                 tx_enable,
    output logic                 tx_bit_tick,
    input  logic                 rx_enable,
    input  logic                 rx_start,
    output logic                 rx_os_tick,
    output logic                 rx_sample_tick
);

    localparam int unsigned OCW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned DEF_RAW   = NATIVE_CLK_FREQUENCY / (DEFAULT_BAUD * OVERSAMPLE);
    localparam int unsigned DEF_CLAMP = (DEF_RAW == 0) ? 1 : DEF_RAW;

    localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(DEF_CLAMP);
    localparam logic [OCW-1:0]       OC_LAST     = OCW'(OVERSAMPLE - 1);
    localparam logic [OCW-1:0]       OC_MID      = OCW'(OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0] r_div;

    logic [DIV_WIDTH-1:0] r_tx_pc;
    logic [OCW-1:0]       r_tx_oc;
    logic                 r_tx_tick;

    logic [DIV_WIDTH-1:0] r_rx_pc;
    logic [OCW-1:0]       r_rx_oc;
    logic                 r_rx_os;
    logic                 r_rx_smp;
    logic                 r_rx_active;

    logic                 w_cfg_fire;
    logic [DIV_WIDTH-1:0] w_cfg_div;
    logic [DIV_WIDTH-1:0] w_div_last;

    logic                 w_tx_os;
    logic                 w_tx_bit;
    logic [DIV_WIDTH-1:0] w_tx_pc_nxt;
    logic [OCW-1:0]       w_tx_oc_nxt;

    logic                 w_rx_align;
    logic [DIV_WIDTH-1:0] w_rx_pc_eff;
    logic [OCW-1:0]       w_rx_oc_eff;
    logic                 w_rx_os;
    logic                 w_rx_smp;
    logic [DIV_WIDTH-1:0] w_rx_pc_nxt;
    logic [OCW-1:0]       w_rx_oc_nxt;

    assign cfg_ready      = !tx_enable && !rx_enable;
    assign div_current    = r_div;
    assign tx_bit_tick    = r_tx_tick;
    assign rx_os_tick     = r_rx_os;
    assign rx_sample_tick = r_rx_smp;

    assign w_cfg_fire = cfg_valid && cfg_ready;
    assign w_cfg_div  = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
    assign w_div_last = r_div - 1'b1;

    // TX event decode from the current counter values
    assign w_tx_os  = (r_tx_pc == w_div_last);
    assign w_tx_bit = w_tx_os && (r_tx_oc == OC_LAST);

    // RX alignment: counters are treated as zero at the aligning edge, so the
    // first oversample event lands D-1 edges later, the first sample at
    // (OVERSAMPLE/2)*D-1 edges later.
    assign w_rx_align  = rx_enable && (!r_rx_active || rx_start);
    assign w_rx_pc_eff = w_rx_align ? '0 : r_rx_pc;
    assign w_rx_oc_eff = w_rx_align ? '0 : r_rx_oc;
    assign w_rx_os     = (w_rx_pc_eff == w_div_last);
    assign w_rx_smp    = w_rx_os && (w_rx_oc_eff == OC_MID);

    // TX next-state; a disabled channel holds zero (a config transfer can only
    // happen while disabled, so it needs no separate clear)
    always_comb begin
        w_tx_pc_nxt = '0;
        w_tx_oc_nxt = '0;
        if (tx_enable) begin
            w_tx_pc_nxt = w_tx_os ? '0 : r_tx_pc + 1'b1;
            if (w_tx_os) begin
                w_tx_oc_nxt = (r_tx_oc == OC_LAST) ? '0 : r_tx_oc + 1'b1;
            end else begin
                w_tx_oc_nxt = r_tx_oc;
            end
        end
    end

    // RX next-state from the (possibly re-aligned) effective counters
    always_comb begin
        w_rx_pc_nxt = '0;
        w_rx_oc_nxt = '0;
        if (rx_enable) begin
            w_rx_pc_nxt = w_rx_os ? '0 : w_rx_pc_eff + 1'b1;
            if (w_rx_os) begin
                w_rx_oc_nxt = (w_rx_oc_eff == OC_LAST) ? '0 : w_rx_oc_eff + 1'b1;
            end else begin
                w_rx_oc_nxt = w_rx_oc_eff;
            end
        end
    end

    // Divisor register: loads on a valid/ready handshake, zero stored as one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= DEFAULT_DIV;
        end else if (w_cfg_fire) begin
            r_div <= w_cfg_div;
        end
    end

    // TX counters and registered bit strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_pc   <= '0;
            r_tx_oc   <= '0;
            r_tx_tick <= 1'b0;
        end else begin
            r_tx_pc   <= w_tx_pc_nxt;
            r_tx_oc   <= w_tx_oc_nxt;
            r_tx_tick <= tx_enable && w_tx_bit;
        end
    end

    // RX counters, enable history for first-edge alignment, registered strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_pc     <= '0;
            r_rx_oc     <= '0;
            r_rx_os     <= 1'b0;
            r_rx_smp    <= 1'b0;
            r_rx_active <= 1'b0;
        end else begin
            r_rx_pc     <= w_rx_pc_nxt;
            r_rx_oc     <= w_rx_oc_nxt;
            r_rx_os     <= rx_enable && w_rx_os;
            r_rx_smp    <= rx_enable && w_rx_smp;
            r_rx_active <= rx_enable;
        end
    end

endmodule
